// File: rtl/rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_driver
// Brief    : Three-channel 8-bit PWM LED driver with period-boundary duty shadowing
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pwm_driver #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rgb,
  input  logic        enable,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        period_done
);

  localparam logic [15:0] c_PRE_MAX = 16'(DIV - 1);

  logic [15:0] r_pre_cnt;
  logic [7:0]  r_cnt;
  logic [7:0]  r_duty_r;
  logic [7:0]  r_duty_g;
  logic [7:0]  r_duty_b;
  logic        r_led_r;
  logic        r_led_g;
  logic        r_led_b;
  logic        r_period_done;

  logic        w_tick;
  logic        w_wrap;

  assign w_tick = enable & (r_pre_cnt == c_PRE_MAX);
  assign w_wrap = w_tick & (r_cnt == 8'hFF);

  // Duty shadows reload only on the wrap so a mid-period rgb change cannot glitch a pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt     <= 16'd0;
      r_cnt         <= 8'd0;
      r_duty_r      <= 8'd0;
      r_duty_g      <= 8'd0;
      r_duty_b      <= 8'd0;
      r_led_r       <= 1'b0;
      r_led_g       <= 1'b0;
      r_led_b       <= 1'b0;
      r_period_done <= 1'b0;
    end else begin
      r_period_done <= 1'b0;
      if (enable) begin
        r_pre_cnt <= w_tick ? 16'd0 : r_pre_cnt + 16'd1;
        if (w_tick) begin
          r_cnt <= r_cnt + 8'd1;
        end
        if (w_wrap) begin
          r_duty_r      <= rgb[23:16];
          r_duty_g      <= rgb[15:8];
          r_duty_b      <= rgb[7:0];
          r_period_done <= 1'b1;
        end
        r_led_r <= (r_cnt < r_duty_r);
        r_led_g <= (r_cnt < r_duty_g);
        r_led_b <= (r_cnt < r_duty_b);
      end else begin
        r_led_r <= 1'b0;
        r_led_g <= 1'b0;
        r_led_b <= 1'b0;
      end
    end
  end

  assign led_r       = r_led_r;
  assign led_g       = r_led_g;
  assign led_b       = r_led_b;
  assign period_done = r_period_done;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pwm_driver
// Brief    : Directed self-checking bench for rgb_pwm_driver (DIV=1 and DIV=4 instances)
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst1 = 1'b1, en1 = 1'b0;
  logic [23:0] rgb1 = 24'h0;
  logic        r1, g1, b1, pd1;
  logic        rst4 = 1'b1, en4 = 1'b0;
  logic [23:0] rgb4 = 24'h0;
  logic        r4, g4, b4, pd4;
  logic        sel = 1'b0;
  logic        m_r, m_g, m_b, m_pd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.DIV(1)) u_d1 (
    .clk(clk), .rst(rst1), .rgb(rgb1), .enable(en1),
    .led_r(r1), .led_g(g1), .led_b(b1), .period_done(pd1)
  );

  rgb_pwm_driver #(.DIV(4)) u_d4 (
    .clk(clk), .rst(rst4), .rgb(rgb4), .enable(en4),
    .led_r(r4), .led_g(g4), .led_b(b4), .period_done(pd4)
  );

  assign m_r  = sel ? r4  : r1;
  assign m_g  = sel ? g4  : g1;
  assign m_b  = sel ? b4  : b1;
  assign m_pd = sel ? pd4 : pd1;

  // Runs n cycles on the selected instance, counting high samples and period_done pulses.
  task automatic measure(input int n, input int chg_at, input logic [23:0] chg_val,
                         output int hr, output int hg, output int hb,
                         output int pd_first, output int pd_last, output int pd_n);
    hr = 0; hg = 0; hb = 0; pd_first = 0; pd_last = 0; pd_n = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (m_r) hr++;
      if (m_g) hg++;
      if (m_b) hb++;
      if (m_pd) begin
        pd_n++;
        if (pd_first == 0) pd_first = i;
        pd_last = i;
      end
      if (i == chg_at) begin
        if (sel) rgb4 = chg_val;
        else     rgb1 = chg_val;
      end
    end
  endtask

  task automatic test_reset;
    int hr, hg, hb, pf, pl, pn;
    sel = 1'b1; rgb4 = 24'hFFFFFF; en4 = 1'b1;
    @(posedge clk); #1; rst4 = 1'b0;
    measure(1024, 0, 24'h0, hr, hg, hb, pf, pl, pn);
    n_checks++;
    if (hr !== 0 || pf !== 1024 || pn !== 1) begin
      n_errors++; $display("FAIL reset_first_period: hr=%0d pd_at=%0d pd_n=%0d, want 0/1024/1", hr, pf, pn);
    end
    measure(300, 0, 24'h0, hr, hg, hb, pf, pl, pn);
    n_checks++;
    if (m_r !== 1'b1 || hr !== 300) begin
      n_errors++; $display("FAIL reset_pre_running: led_r=%b hr=%0d, want 1/300", m_r, hr);
    end
    #3 rst4 = 1'b1;
    #1;
    n_checks++;
    if ({r4, g4, b4, pd4} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_async_clear: rgbpd=%b, want 0000", {r4, g4, b4, pd4});
    end
    @(posedge clk); #1; rst4 = 1'b0;
    measure(1024, 0, 24'h0, hr, hg, hb, pf, pl, pn);
    n_checks++;
    if (hr !== 0 || hg !== 0 || hb !== 0 || pf !== 1024 || pn !== 1) begin
      n_errors++; $display("FAIL reset_restart: h=%0d/%0d/%0d pd_at=%0d pd_n=%0d, want 0/0/0 1024 1",
                           hr, hg, hb, pf, pn);
    end
    measure(1024, 0, 24'h0, hr, hg, hb, pf, pl, pn);
    n_checks++;
    if (hr !== 1020 || hg !== 1020 || hb !== 1020) begin
      n_errors++; $display("FAIL reset_div4_duty_ff: h=%0d/%0d/%0d, want 1020 each", hr, hg, hb);
    end
  endtask

  task automatic test_period_div4;
    int hr, hg, hb, pf, pl, pn;
    sel = 1'b1;
    measure(2048, 0, 24'h0, hr, hg, hb, pf, pl, pn);
    n_checks++;
    if (pf !== 1024 || pl !== 2048 || pn !== 2) begin
      n_errors++; $display("FAIL period_div4: first=%0d last=%0d n=%0d, want 1024/2048/2", pf, pl, pn);
    end
  endtask

  task automatic test_duty_mix;
    int hr, hg, hb, pf, pl, pn;
    sel = 1'b0; rst1 = 1'b1; rgb1 = 24'hFF8000; en1 = 1'b1;
    @(posedge clk); #1; rst1 = 1'b0;
    measure(256, 0, 24'h0, hr, hg, hb, pf, pl, pn);
    n_checks++;
    if (hr !== 0 || hg !== 0 || hb !== 0 || pf !== 256 || pn !== 1) begin
      n_errors++; $display("FAIL mix_first_period: h=%0d/%0d/%0d pd_at=%0d n=%0d, want 0/0/0 256 1",
                           hr, hg, hb, pf, pn);
    end
    measure(256, 0, 24'h0, hr, hg, hb, pf, pl, pn);
    n_checks++;
    if (hr !== 255 || hg !== 128 || hb !== 0) begin
      n_errors++; $display("FAIL mix_high_counts: h=%0d/%0d/%0d, want 255/128/0", hr, hg, hb);
    end
    n_checks++;
    if (pf !== 256 || pn !== 1) begin
      n_errors++; $display("FAIL mix_period_div1: pd_at=%0d n=%0d, want 256/1", pf, pn);
    end
  endtask

  task automatic test_shadow;
    int hr, hg, hb, pf, pl, pn;
    sel = 1'b0; rgb1 = 24'h404040;
    measure(256, 0, 24'h0, hr, hg, hb, pf, pl, pn);
    measure(256, 100, 24'hC0C0C0, hr, hg, hb, pf, pl, pn);
    n_checks++;
    if (hr !== 64 || hg !== 64 || hb !== 64) begin
      n_errors++; $display("FAIL shadow_hold: h=%0d/%0d/%0d, want 64 each", hr, hg, hb);
    end
    measure(256, 0, 24'h0, hr, hg, hb, pf, pl, pn);
    n_checks++;
    if (hr !== 192 || hg !== 192 || hb !== 192) begin
      n_errors++; $display("FAIL shadow_reload: h=%0d/%0d/%0d, want 192 each", hr, hg, hb);
    end
  endtask

  task automatic test_enable_pause;
    int hr = 0, dis_high = 0, pf = 0, pn = 0;
    sel = 1'b0;
    for (int i = 1; i <= 266; i++) begin
      @(posedge clk); #1;
      if (r1) hr++;
      if (i >= 51 && i <= 60 && (r1 || g1 || b1 || pd1)) dis_high++;
      if (pd1) begin
        pn++;
        if (pf == 0) pf = i;
      end
      if (i == 50) en1 = 1'b0;
      if (i == 60) en1 = 1'b1;
    end
    n_checks++;
    if (dis_high !== 0) begin
      n_errors++; $display("FAIL pause_outputs_off: active samples=%0d, want 0", dis_high);
    end
    n_checks++;
    if (pf !== 266 || pn !== 1) begin
      n_errors++; $display("FAIL pause_period_len: pd_at=%0d n=%0d, want 266/1", pf, pn);
    end
    n_checks++;
    if (hr !== 192) begin
      n_errors++; $display("FAIL pause_duty_kept: hr=%0d, want 192", hr);
    end
  endtask

  task automatic test_extremes;
    int hr, hg, hb, pf, pl, pn;
    sel = 1'b0; rst1 = 1'b1; rgb1 = 24'h000000; en1 = 1'b1;
    @(posedge clk); #1; rst1 = 1'b0;
    measure(256, 0, 24'h0, hr, hg, hb, pf, pl, pn);
    measure(256, 1, 24'hFFFFFF, hr, hg, hb, pf, pl, pn);
    n_checks++;
    if (hr !== 0 || hg !== 0 || hb !== 0) begin
      n_errors++; $display("FAIL duty_zero: h=%0d/%0d/%0d, want 0 each", hr, hg, hb);
    end
    measure(256, 0, 24'h0, hr, hg, hb, pf, pl, pn);
    n_checks++;
    if (hr !== 255 || hg !== 255 || hb !== 255) begin
      n_errors++; $display("FAIL duty_full: h=%0d/%0d/%0d, want 255 each", hr, hg, hb);
    end
  endtask

  task automatic test_reset_values;
    #1;
    n_checks++;
    if ({r1, g1, b1, pd1, r4, g4, b4, pd4} !== 8'h00) begin
      n_errors++; $display("FAIL reset_values: outs=%b, want 00000000",
                           {r1, g1, b1, pd1, r4, g4, b4, pd4});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset_values();
    test_reset();
    test_period_div4();
    test_duty_mix();
    test_shadow();
    test_enable_pause();
    test_extremes();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
